// File: rtl/vga_sprite_pkg.sv
// Shared constants for every client of the button-overlay sprite ROM:
// image geometry, pixel format and the default ROM read latency.
package vga_sprite_pkg;

  localparam int IMG_W   = 584;  // image width in pixels, valid col 0..IMG_W-1
  localparam int IMG_H   = 167;  // image height in pixels, valid row 0..IMG_H-1
  localparam int PIX_W   = 12;   // RGB444
  localparam int ROM_LAT = 1;    // address-to-data latency of the sprite ROM

  localparam logic [PIX_W-1:0] PIX_BLACK = 12'h000;

  // Larger of two integers; used to size coordinate comparators.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr and
// wrapping, returns a one-hot grant plus the granted index. The pointer
// register itself lives in the instantiating block.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] cand;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
        pos = pos - (IDX_W + 1)'(NUM_REQ);
      end
      cand = pos[IDX_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-output sprite ROM among NUM_REQ pixel requesters.
// One lookup per cycle, round-robin grant, fixed 1+ROM_LAT latency, responses
// in grant order tagged with requester id. Out-of-image coordinates skip the
// ROM (address forced to 0/0) and answer black.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 10,
  parameter int DATA_W  = vga_sprite_pkg::PIX_W,
  parameter int IMG_W   = vga_sprite_pkg::IMG_W,
  parameter int IMG_H   = vga_sprite_pkg::IMG_H,
  parameter int ROM_LAT = vga_sprite_pkg::ROM_LAT,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ROW_W-1:0]   req_row,
  input  logic [NUM_REQ*COL_W-1:0]   req_col,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ROW_W-1:0]           rom_row,
  output logic [COL_W-1:0]           rom_col,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       rsp_valid,
  output logic [IDX_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_oob
);

  localparam int CMP_W = vga_sprite_pkg::max_int(ROW_W, COL_W) + 1;

  // One in-flight lookup; invalid slots are held at all-zero.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
    logic             oob;
  } tag_t;

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] arb_req;
  logic [IDX_W-1:0]   arb_idx;
  logic               grant;
  logic [ROW_W-1:0]   sel_row;
  logic [COL_W-1:0]   sel_col;
  logic [CMP_W-1:0]   row_ext;
  logic [CMP_W-1:0]   col_ext;
  logic               sel_oob;
  tag_t               tag_q [ROM_LAT+1];

  // Nothing may be granted while disabled or held in reset.
  assign arb_req = req & {NUM_REQ{en & rst_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (arb_idx),
    .any (grant)
  );

  // Coordinates of the granted requester and their bounds check.
  always_comb begin
    sel_row = req_row[arb_idx*ROW_W +: ROW_W];
    sel_col = req_col[arb_idx*COL_W +: COL_W];
    row_ext = CMP_W'(sel_row);
    col_ext = CMP_W'(sel_col);
    sel_oob = (row_ext >= CMP_W'(IMG_H)) || (col_ext >= CMP_W'(IMG_W));
  end

  // Round-robin pointer: moves past the winner, holds when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ptr <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // ROM address register; out-of-image requests park the address at 0/0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_row <= '0;
      rom_col <= '0;
    end else if (grant) begin
      rom_row <= sel_oob ? '0 : sel_row;
      rom_col <= sel_oob ? '0 : sel_col;
    end
  end

  // Tag shift register, one slot per cycle of request-to-response latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag array is reset slot by slot because its valid bits
      // must drop immediately; an unreset array would replay stale responses.
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= grant ? '{valid: 1'b1, id: arb_idx, oob: sel_oob} : '0;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Response: ROM pixel for in-image lookups, black otherwise or when idle.
  always_comb begin
    rsp_valid = tag_q[ROM_LAT].valid;
    rsp_id    = tag_q[ROM_LAT].id;
    rsp_oob   = tag_q[ROM_LAT].oob;
    rsp_data  = (tag_q[ROM_LAT].valid && !tag_q[ROM_LAT].oob)
                ? rom_data : DATA_W'(vga_sprite_pkg::PIX_BLACK);
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter. Two instances share all inputs:
// dut1 with ROM_LAT=1 and dut3 with ROM_LAT=3, each fed by its own
// behavioural ROM whose contents come from the pix() function below.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_row;
  logic [39:0] req_col;

  logic [3:0]  gnt1, gnt3;
  logic [7:0]  rom_row1, rom_row3;
  logic [9:0]  rom_col1, rom_col3;
  logic [11:0] rom_data1, rom_data3;
  logic        rsp_valid1, rsp_valid3;
  logic [1:0]  rsp_id1, rsp_id3;
  logic [11:0] rsp_data1, rsp_data3;
  logic        rsp_oob1, rsp_oob3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_row(req_row), .req_col(req_col),
    .gnt(gnt1), .rom_row(rom_row1), .rom_col(rom_col1), .rom_data(rom_data1),
    .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_data(rsp_data1), .rsp_oob(rsp_oob1)
  );

  sprite_rom_arbiter #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_row(req_row), .req_col(req_col),
    .gnt(gnt3), .rom_row(rom_row3), .rom_col(rom_col3), .rom_data(rom_data3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_data(rsp_data3), .rsp_oob(rsp_oob3)
  );

  // Sprite image model: pixel value is a hash of the linear address.
  function automatic logic [11:0] pix(input int r, input int c);
    int a;
    a = r * 584 + c;
    return 12'((a * 37 + 5) & 12'hFFF);
  endfunction

  logic [11:0] rom3_q [3];

  always @(posedge clk) begin
    rom_data1  <= pix(int'(rom_row1), int'(rom_col1));
    rom3_q[0]  <= pix(int'(rom_row3), int'(rom_col3));
    rom3_q[1]  <= rom3_q[0];
    rom3_q[2]  <= rom3_q[1];
  end
  assign rom_data3 = rom3_q[2];

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coord(input int i, input int r, input int c);
    req_row[i*8 +: 8]   = 8'(r);
    req_col[i*10 +: 10] = 10'(c);
  endtask

  task automatic drain();
    req = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    en    = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    req     = 4'b1111;
    req_row = '0;
    req_col = '0;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt1); end
    n_checks++;
    if (rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid1); end
    n_checks++;
    if (rom_row1 !== 8'd0 || rom_col1 !== 10'd0) begin
      n_fail++; $display("FAIL reset_rom_addr: got %0d/%0d want 0/0", rom_row1, rom_col1);
    end
    n_checks++;
    if (rsp_id1 !== 2'd0 || rsp_oob1 !== 1'b0 || rsp_data1 !== 12'h000) begin
      n_fail++; $display("FAIL reset_rsp_fields: got id=%0d oob=%b data=%h want 0/0/000", rsp_id1, rsp_oob1, rsp_data1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 0001", gnt1); end
    tick();
    drain();
  endtask

  // Pointer is 1 here (requester 0 won last), so requester 2 wins alone.
  task automatic test_single();
    set_coord(2, 10, 20);
    req = 4'b0100;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", gnt1); end
    tick();
    req = 4'b0000;
    n_checks++;
    if (rom_row1 !== 8'd10 || rom_col1 !== 10'd20) begin
      n_fail++; $display("FAIL single_rom_addr: got %0d/%0d want 10/20", rom_row1, rom_col1);
    end
    n_checks++;
    if (rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid1); end
    tick();
    n_checks++;
    if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd2 || rsp_oob1 !== 1'b0 || rsp_data1 !== pix(10, 20)) begin
      n_fail++; $display("FAIL single_rsp: got v=%b id=%0d oob=%b data=%h want 1/2/0/%h",
                         rsp_valid1, rsp_id1, rsp_oob1, rsp_data1, pix(10, 20));
    end
    tick();
    n_checks++;
    if (rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL single_rsp_once: got %b want 0", rsp_valid1); end
    drain();
  endtask

  task automatic test_fairness();
    int id;
    do_reset();
    for (int i = 0; i < 4; i++) set_coord(i, 30 + i, 100 * i + 7);
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        n_checks++;
        if (gnt1 !== 4'(1 << (c % 4))) begin
          n_fail++; $display("FAIL fair_gnt c%0d: got %b want %b", c, gnt1, 4'(1 << (c % 4)));
        end
      end
      n_checks++;
      if (c < 2) begin
        if (rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL fair_idle c%0d: got %b want 0", c, rsp_valid1); end
      end else begin
        id = (c - 2) % 4;
        if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'(id) || rsp_data1 !== pix(30 + id, 100 * id + 7)) begin
          n_fail++; $display("FAIL fair_rsp c%0d: got v=%b id=%0d data=%h want 1/%0d/%h",
                             c, rsp_valid1, rsp_id1, rsp_data1, id, pix(30 + id, 100 * id + 7));
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_hold();
    set_coord(0, 1, 2);
    for (int c = 0; c < 4; c++) begin
      req = 4'b0001;
      #1;
      n_checks++;
      if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL hold_gnt c%0d: got %b want 0001", c, gnt1); end
      tick();
    end
    drain();
  endtask

  task automatic test_bounds();
    int  rows [4] = '{166, 167, 0, 255};
    int  cols [4] = '{583, 0, 584, 1023};
    logic oobs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [11:0] want;
    for (int v = 0; v < 4; v++) begin
      set_coord(1, rows[v], cols[v]);
      req = 4'b0010;
      #1;
      n_checks++;
      if (gnt1 !== 4'b0010) begin n_fail++; $display("FAIL bounds_gnt v%0d: got %b want 0010", v, gnt1); end
      tick();
      req = 4'b0000;
      n_checks++;
      if (rom_row1 !== (oobs[v] ? 8'd0 : 8'(rows[v])) || rom_col1 !== (oobs[v] ? 10'd0 : 10'(cols[v]))) begin
        n_fail++; $display("FAIL bounds_rom_addr v%0d: got %0d/%0d", v, rom_row1, rom_col1);
      end
      tick();
      want = oobs[v] ? 12'h000 : pix(rows[v], cols[v]);
      n_checks++;
      if (rsp_valid1 !== 1'b1 || rsp_oob1 !== oobs[v] || rsp_data1 !== want) begin
        n_fail++; $display("FAIL bounds_rsp v%0d: got v=%b oob=%b data=%h want 1/%b/%h",
                           v, rsp_valid1, rsp_oob1, rsp_data1, oobs[v], want);
      end
    end
    drain();
  endtask

  task automatic test_en();
    do_reset();
    set_coord(1, 20, 30);
    set_coord(2, 40, 50);
    en  = 1'b0;
    req = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (gnt1 !== 4'b0000 || rsp_valid1 !== 1'b0) begin
        n_fail++; $display("FAIL en_off c%0d: got gnt=%b v=%b want 0000/0", c, gnt1, rsp_valid1);
      end
      tick();
    end
    en = 1'b1;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0010) begin n_fail++; $display("FAIL en_rise_gnt: got %b want 0010", gnt1); end
    tick();
    en = 1'b0;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0000) begin n_fail++; $display("FAIL en_fall_gnt: got %b want 0000", gnt1); end
    tick();
    n_checks++;
    if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd1 || rsp_data1 !== pix(20, 30)) begin
      n_fail++; $display("FAIL en_drain_rsp: got v=%b id=%0d data=%h want 1/1/%h",
                         rsp_valid1, rsp_id1, rsp_data1, pix(20, 30));
    end
    tick();
    n_checks++;
    if (rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL en_no_new_rsp: got %b want 0", rsp_valid1); end
    tick();
    n_checks++;
    if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd1 || rsp_data3 !== pix(20, 30)) begin
      n_fail++; $display("FAIL en_drain_rsp_lat3: got v=%b id=%0d data=%h want 1/1/%h",
                         rsp_valid3, rsp_id3, rsp_data3, pix(20, 30));
    end
    en = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_coord(1, 5, 6);
    req = 4'b0010;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt: got %b want 0010", gnt1); end
    tick();
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid1 !== 1'b0 || rom_row1 !== 8'd0 || rom_col1 !== 10'd0) begin
      n_fail++; $display("FAIL mid_async_clear: got v=%b addr=%0d/%0d want 0/0/0", rsp_valid1, rom_row1, rom_col1);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (rsp_valid1 !== 1'b0 || rsp_valid3 !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_rsp c%0d: got v1=%b v3=%b want 0/0", c, rsp_valid1, rsp_valid3);
      end
      tick();
    end
    req = 4'b1111;
    #1;
    n_checks++;
    if (gnt1 !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset: got %b want 0001", gnt1); end
    tick();
    drain();
  endtask

  task automatic test_lat3();
    set_coord(2, 10, 20);
    req = 4'b0100;
    #1;
    n_checks++;
    if (gnt3 !== 4'b0100) begin n_fail++; $display("FAIL lat3_gnt: got %b want 0100", gnt3); end
    tick();
    req = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (rsp_valid3 !== 1'b0) begin n_fail++; $display("FAIL lat3_early k%0d: got %b want 0", k, rsp_valid3); end
      tick();
    end
    n_checks++;
    if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd2 || rsp_oob3 !== 1'b0 || rsp_data3 !== pix(10, 20)) begin
      n_fail++; $display("FAIL lat3_rsp: got v=%b id=%0d oob=%b data=%h want 1/2/0/%h",
                         rsp_valid3, rsp_id3, rsp_oob3, rsp_data3, pix(10, 20));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_bounds();
    test_en();
    test_reset_mid();
    test_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
